// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: widths, operation codes and the issuer FSM state.
package alu_pkg;

  localparam int WIDTH  = 16;
  localparam int CODE_W = 5;
  localparam int CNT_W  = 4;

  // Arithmetic group: code[4:3] == 2'b00
  localparam logic [CODE_W-1:0] ALU_ADD_S = 5'b00000;
  localparam logic [CODE_W-1:0] ALU_ADD_U = 5'b00001;
  localparam logic [CODE_W-1:0] ALU_SUB_S = 5'b00010;
  localparam logic [CODE_W-1:0] ALU_SUB_U = 5'b00011;
  localparam logic [CODE_W-1:0] ALU_INC   = 5'b00100;
  localparam logic [CODE_W-1:0] ALU_DEC   = 5'b00101;
  localparam logic [CODE_W-1:0] ALU_AND   = 5'b01000;
  localparam logic [CODE_W-1:0] ALU_OR    = 5'b01001;
  localparam logic [CODE_W-1:0] ALU_XOR   = 5'b01010;
  localparam logic [CODE_W-1:0] ALU_NOT   = 5'b01100;
  localparam logic [CODE_W-1:0] ALU_SLL   = 5'b10000;
  localparam logic [CODE_W-1:0] ALU_SRL   = 5'b10001;
  localparam logic [CODE_W-1:0] ALU_SLA   = 5'b10010;
  localparam logic [CODE_W-1:0] ALU_SRA   = 5'b10011;
  localparam logic [CODE_W-1:0] ALU_LE    = 5'b11000;
  localparam logic [CODE_W-1:0] ALU_LT    = 5'b11001;
  localparam logic [CODE_W-1:0] ALU_GE    = 5'b11010;
  localparam logic [CODE_W-1:0] ALU_GT    = 5'b11011;
  localparam logic [CODE_W-1:0] ALU_EQ    = 5'b11100;
  localparam logic [CODE_W-1:0] ALU_NE    = 5'b11101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_code_decode.sv
// Combinational classifier for alu_code: flags defined operations and the arithmetic group.
module alu_code_decode
  import alu_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic              o_is_legal,
  output logic              o_is_arith
);

  always_comb begin
    o_is_legal = 1'b0;
    o_is_arith = (i_code[4:3] == 2'b00);
    case (i_code)
      ALU_ADD_S, ALU_ADD_U, ALU_SUB_S, ALU_SUB_U, ALU_INC, ALU_DEC,
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
      ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA,
      ALU_LE, ALU_LT, ALU_GE, ALU_GT, ALU_EQ, ALU_NE: o_is_legal = 1'b1;
      default:                                        o_is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation at a time: drives A/B/code, waits a settle window, returns a tagged result.
// Optional macro ALU_ISSUER_OVF_STICKY_EN adds ovf_clr / ovf_sticky (sticky masked-overflow flag).
module alu_op_issuer #(
  parameter int WIDTH         = alu_pkg::WIDTH,
  parameter int CODE_W        = alu_pkg::CODE_W,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CODE_W-1:0]      req_code,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [CODE_W-1:0]      alu_code,
  input  logic [WIDTH-1:0]       alu_c,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_c,
  output logic                   rsp_overflow,
  output logic                   rsp_illegal,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy,
`ifdef ALU_ISSUER_OVF_STICKY_EN
  input  logic                   ovf_clr,
  output logic                   ovf_sticky,
`endif
  output alu_pkg::issuer_state_e dbg_state
);
  import alu_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // Once rsp_valid rises it stays high with rsp_* frozen until rsp_ready is seen.

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  issuer_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic              r_arith;
  logic [WIDTH-1:0]  r_alu_a, r_alu_b;
  logic [CODE_W-1:0] r_alu_code;
  logic              r_rsp_valid, r_rsp_ovf, r_rsp_ill;
  logic [WIDTH-1:0]  r_rsp_c;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic w_legal, w_arith;
  logic w_accept, w_capture, w_rsp_arm, w_rsp_done;

  alu_code_decode u_decode (
    .i_code     (req_code),
    .o_is_legal (w_legal),
    .o_is_arith (w_arith)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Illegal ops enter RESP with rsp_valid low for one cycle so that every
  // response, legal or not, appears no earlier than the edge after accept.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_arm   = 1'b0;
    w_rsp_done  = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_legal ? ST_DRIVE : ST_RESP;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!r_rsp_valid) begin
          w_rsp_arm = 1'b1;
        end else if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_tag       <= '0;
      r_arith     <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_code  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_c     <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_ill   <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_accept) begin
        r_tag   <= req_tag;
        r_arith <= w_arith;
        if (w_legal) begin
          r_alu_a    <= req_a;
          r_alu_b    <= req_b;
          r_alu_code <= req_code;
          r_cnt      <= SETTLE_LOAD;
        end else begin
          r_rsp_c   <= '0;
          r_rsp_ovf <= 1'b0;
          r_rsp_ill <= 1'b1;
          r_rsp_tag <= req_tag;
        end
      end
      if ((r_state == ST_DRIVE) && !w_capture) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Overflow only has meaning for the arithmetic group; mask it elsewhere.
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_c     <= alu_c;
        r_rsp_ovf   <= alu_overflow & r_arith;
        r_rsp_ill   <= 1'b0;
        r_rsp_tag   <= r_tag;
      end
      if (w_rsp_arm)  r_rsp_valid <= 1'b1;
      if (w_rsp_done) r_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUER_OVF_STICKY_EN
  logic r_ovf_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_ovf_sticky <= 1'b0;
    else if (w_capture && alu_overflow && r_arith) r_ovf_sticky <= 1'b1;
    else if (ovf_clr)                             r_ovf_sticky <= 1'b0;
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_code     = r_alu_code;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_c        = r_rsp_c;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_illegal  = r_rsp_ill;
  assign rsp_tag      = r_rsp_tag;
  assign busy         = (r_state != ST_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the 16-bit ALU operand/code interface. Accepts operation requests over a valid/ready channel and drives the ALU's A, B and alu_code inputs. It holds them stable for a settle window, captures C/overflow, and returns a tagged response over a second valid/ready channel. It sits between the instruction-level controller and the combinational ALU and is the only block that drives ALU inputs.

Parameters:
WIDTH, 16, operand/result width (matches ALU A/B/C)
CODE_W, 5, alu_code width
TAG_W, 4, request tag width, echoed on response
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  issuer can accept request
req_code  in  CODE_W  ALU operation code
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_tag  in  TAG_W  request tag
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_code  out  CODE_W  to ALU alu_code
alu_c  in  WIDTH  from ALU C
alu_overflow  in  1  from ALU overflow
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_c  out  WIDTH  captured result
rsp_overflow  out  1  captured overflow (masked, see below)
rsp_illegal  out  1  request code was not a defined ALU op
rsp_tag  out  TAG_W  echoed tag
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. All registers clear immediately on rst_n low.
- Reset values: req_ready=1 after release, rsp_valid=0, rsp_c=0, rsp_overflow=0, rsp_illegal=0, rsp_tag=0, alu_a=0, alu_b=0, alu_code=0, busy=0.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, register code/a/b/tag.
  - Legal code: go to DRIVE, load settle counter with SETTLE_CYCLES-1.
  - Illegal code: go directly to RESP with rsp_c=0, rsp_overflow=0, rsp_illegal=1. alu_* outputs are not updated.
- Legal codes:
  - arithmetic 00000-00101
  - logic 01000, 01001, 01010, 01100
  - shift 10000-10011
  - compare 11000-11101
  - All other codes are illegal.
- DRIVE: alu_a/alu_b/alu_code are registered outputs, stable from the accept edge. The counter decrements each cycle. At count==0, the next edge captures alu_c into rsp_c and moves to RESP with rsp_valid=1.
- Overflow masking: rsp_overflow is alu_overflow for arithmetic codes (code[4:3]==00) and forced to 0 for every other code.
- Latency: with accept at edge k, rsp_valid is high after edge k+SETTLE_CYCLES. For illegal codes, rsp_valid is high after edge k+1.
- RESP: rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&rsp_ready, go to IDLE and clear rsp_valid on that edge.
- req_ready=0 in DRIVE and RESP. No back-to-back overlap, so throughput is one op per SETTLE_CYCLES+2 cycles.
- alu_* outputs keep their last issued values in IDLE and RESP. They are not zeroed, to avoid ALU toggling.
- Reset mid-operation (DRIVE or RESP): the in-flight op is dropped, no response is produced, and the block returns to IDLE at reset values.
- req_valid is ignored outside IDLE. Request fields are don't-care when req_valid=0.

Optional Feature:
Macro ALU_ISSUER_OVF_STICKY_EN.
- Defined: adds input ovf_clr (1) and output ovf_sticky (1).
  - ovf_sticky sets on the capture edge of any response whose masked overflow is 1.
  - It clears synchronously on ovf_clr=1. If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- Undefined: neither port exists and no sticky register is built. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - WIDTH and CODE_W localparams
  - named constants for all 20 alu_code values (ALU_ADD_S, ALU_ADD_U, ALU_SUB_S, ALU_SUB_U, ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA, ALU_LE, ALU_LT, ALU_GE, ALU_GT, ALU_EQ, ALU_NE)
  - issuer FSM state enum
- One combinational sub-module, alu_code_decode: code in; is_legal and is_arith out. It is reused later by the controller.

Test Plan:
- Reset then req code=00000, a=16'h7FFF, b=16'h0001, tag=3 with an ALU model attached, SETTLE_CYCLES=1 -> rsp_valid after edge k+1, rsp_c=16'h8000, rsp_overflow=1, rsp_tag=3, rsp_illegal=0.
- Req code=01000 (AND), a=16'hF0F0, b=16'hFF00 with the ALU model forcing alu_overflow=1 -> rsp_c=16'hF000, rsp_overflow=0 (masked).
- Req code=00110 (illegal), tag=9 -> rsp_valid after edge k+1, rsp_illegal=1, rsp_c=0, and alu_code still shows the previous op.
- Hold rsp_ready=0 for 5 cycles with SETTLE_CYCLES=3 -> rsp_* stable, req_ready=0, and a second req_valid is not accepted. Raise rsp_ready -> IDLE next cycle, second request then accepted.
- Assert rst_n=0 mid-DRIVE -> rsp_valid stays 0, busy=0 and alu_a=0 immediately, no response for the dropped tag after release.
- With ALU_ISSUER_OVF_STICKY_EN defined: two overflow ops, then ovf_clr on the same cycle as a third overflow capture -> ovf_sticky stays 1. Clear again alone -> ovf_sticky goes to 0.
